// File: rtl/ram_moc_seq_if.sv
`default_nettype none
// ============================================================================
//  Module      : ram_moc_seq_if
//  Description : MOV/MOC handshake bundle between the CPU control unit and
//                the data-RAM MOC sequencer, plus beat/status outputs.
//  Revision    : 1.0 - initial release
// ============================================================================
interface ram_moc_seq_if;
    logic       MOV;       // memory operation valid, held until MOC
    logic       RW;        // 1 = read, 0 = write
    logic [1:0] SIZE;      // 00 byte, 01 half, 10 word, 11 reserved
    logic       MOC;       // memory operation complete (level)
    logic       BEAT;      // RAM lane at BEAT_IDX accessed this cycle
    logic [1:0] BEAT_IDX;  // byte lane of current beat
    logic       BUSY;      // access in flight or completed and held
    logic       SIZE_ERR;  // completion of a reserved-size access
    logic       ABORT;     // one-cycle pulse after an early MOV drop

    // Control unit side
    modport master (
        output MOV, RW, SIZE,
        input  MOC, BEAT, BEAT_IDX, BUSY, SIZE_ERR, ABORT
    );

    // Sequencer side
    modport slave (
        input  MOV, RW, SIZE,
        output MOC, BEAT, BEAT_IDX, BUSY, SIZE_ERR, ABORT
    );
endinterface
`default_nettype wire

// File: rtl/ram_moc_seq.sv
`default_nettype none
// ============================================================================
//  Module      : ram_moc_seq
//  Description : Memory-operation-complete sequencer for the 256x8 data RAM.
//                Splits a byte/halfword/word access into per-lane beats,
//                each lasting RD_LAT or WR_LAT cycles, then holds MOC until
//                the control unit drops MOV. Early MOV drop aborts.
//  Revision    : 1.0 - initial release
// ============================================================================
module ram_moc_seq #(
    parameter int RD_LAT = 3,   // cycles per beat for reads  (1..2^CNT_W)
    parameter int WR_LAT = 3,   // cycles per beat for writes (1..2^CNT_W)
    parameter int CNT_W  = 4    // per-beat cycle counter width
) (
    input  wire logic     CLK,
    input  wire logic     RESET,   // asynchronous, active-low
    ram_moc_seq_if.slave  bus
);

    // Latencies are stored as LAT-1 so a counter of CNT_W bits covers
    // the full legal range 1..2^CNT_W without needing an extra bit.
    localparam logic [CNT_W-1:0] C_RD_LAT_M1 = CNT_W'(RD_LAT - 1);
    localparam logic [CNT_W-1:0] C_WR_LAT_M1 = CNT_W'(WR_LAT - 1);

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_ACCESS = 2'd1,
        ST_DONE   = 2'd2
    } state_t;

    state_t           state_q,  state_d;
    logic [CNT_W-1:0] cnt_q,    cnt_d;     // cycle within current beat
    logic [1:0]       idx_q,    idx_d;     // current byte lane
    logic [CNT_W-1:0] lat_m1_q, lat_m1_d;  // latched latency minus one
    logic [1:0]       nb_m1_q,  nb_m1_d;   // latched beat count minus one
    logic [1:0]       size_q,   size_d;    // latched SIZE for error flag
    logic             abort_q,  abort_d;   // abort pulse for the next cycle

    // State and datapath registers; reset discards any access in flight
    always_ff @(posedge CLK or negedge RESET) begin
        if (!RESET) begin
            state_q  <= ST_IDLE;
            cnt_q    <= '0;
            idx_q    <= '0;
            lat_m1_q <= '0;
            nb_m1_q  <= '0;
            size_q   <= '0;
            abort_q  <= 1'b0;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            idx_q    <= idx_d;
            lat_m1_q <= lat_m1_d;
            nb_m1_q  <= nb_m1_d;
            size_q   <= size_d;
            abort_q  <= abort_d;
        end
    end

    // Next-state logic: latch the request in IDLE, walk beats in ACCESS,
    // hold completion in DONE until MOV falls
    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        idx_d    = idx_q;
        lat_m1_d = lat_m1_q;
        nb_m1_d  = nb_m1_q;
        size_d   = size_q;
        abort_d  = 1'b0;

        case (state_q)
            ST_IDLE: begin
                if (bus.MOV) begin
                    size_d   = bus.SIZE;
                    lat_m1_d = bus.RW ? C_RD_LAT_M1 : C_WR_LAT_M1;
                    case (bus.SIZE)
                        2'b00:   nb_m1_d = 2'd0;
                        2'b01:   nb_m1_d = 2'd1;
                        default: nb_m1_d = 2'd3;   // word and reserved
                    endcase
                    cnt_d   = '0;
                    idx_d   = '0;
                    state_d = ST_ACCESS;
                end
            end

            ST_ACCESS: begin
                if (!bus.MOV) begin
                    state_d = ST_IDLE;
                    abort_d = 1'b1;
                end else if (cnt_q != lat_m1_q) begin
                    cnt_d = cnt_q + CNT_W'(1);
                end else if (idx_q != nb_m1_q) begin
                    cnt_d = '0;
                    idx_d = idx_q + 2'd1;
                end else begin
                    state_d = ST_DONE;
                end
            end

            ST_DONE: begin
                if (!bus.MOV) begin
                    state_d = ST_IDLE;
                end
            end

            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // Outputs decoded from registered state; BEAT also gated by live MOV so
    // a lane is never strobed in the cycle the access is being abandoned
    always_comb begin
        bus.MOC      = (state_q == ST_DONE);
        bus.BUSY     = (state_q == ST_ACCESS) || (state_q == ST_DONE);
        bus.SIZE_ERR = (state_q == ST_DONE) && (size_q == 2'b11);
        bus.BEAT     = (state_q == ST_ACCESS) && (cnt_q == lat_m1_q) && bus.MOV;
        bus.BEAT_IDX = (state_q == ST_ACCESS) ? idx_q : 2'd0;
        bus.ABORT    = abort_q;
    end

endmodule
`default_nettype wire

// File: doc/ram_moc_seq.md
Name: ram_moc_seq

Overview:
- Parametrised memory-operation-complete (MOC) sequencer for the byte-wide data RAM.
- Sits between the CPU control unit's MOV/MOC handshake and the 256x8 RAM array.
- Generalises single-latency MOC timing with separate read/write latencies and multi-beat halfword/word accesses.
- Adds per-beat lane strobes, abort detection and a size-error flag.

Parameters:
RD_LAT, 3, cycles per beat for reads (legal 1..2^CNT_W)
WR_LAT, 3, cycles per beat for writes (legal 1..2^CNT_W)
CNT_W, 4, width of the per-beat cycle counter

Ports:
CLK  in  1  system clock, all flops on rising edge
RESET  in  1  asynchronous, active-low reset (0 = reset asserted)
MOV  in  1  memory operation valid from control unit; held high until MOC seen
RW  in  1  1 = read, 0 = write; sampled with MOV in IDLE
SIZE  in  2  00 byte, 01 halfword, 10 word, 11 reserved; sampled with MOV in IDLE
MOC  out  1  memory operation complete; level, held while MOV stays high
BEAT  out  1  one-cycle strobe: the RAM lane at BEAT_IDX is accessed this cycle
BEAT_IDX  out  2  byte lane of the current beat (0..3)
BUSY  out  1  high in ACCESS and DONE
SIZE_ERR  out  1  high with MOC when latched SIZE was 11
ABORT  out  1  one-cycle pulse after MOV drops before completion

Behaviour:
- Reset: RESET=0 forces IDLE immediately, independent of CLK. Mid-operation reset discards the access.
  - All outputs 0 while in reset: MOC, BEAT, BEAT_IDX, BUSY, SIZE_ERR, ABORT.
  - Counters cleared.
- States: IDLE, ACCESS, DONE.
- IDLE:
  - On an edge with MOV=1, latch RW and SIZE, set beat count NB (byte 1, half 2, word 4, reserved 4), cnt=0, idx=0, go ACCESS.
  - Latency register LAT = RW ? RD_LAT : WR_LAT.
- ACCESS, each edge:
  - MOV=0: go IDLE and pulse ABORT for the following cycle. No MOC.
  - Else if cnt != LAT-1: cnt++.
  - Else if idx != NB-1: cnt=0, idx++.
  - Else: go DONE.
- BEAT = (state==ACCESS) && (cnt==LAT-1) && MOV. Decoded from registers plus MOV; no other input dependence.
- BEAT_IDX = idx in ACCESS; 0 otherwise.
- Timing: MOV sampled at edge 0 gives first BEAT in cycle LAT. MOC rises after edge NB*LAT.
  - Byte, LAT=3: MOC high at cycle 4. Word: cycle 13.
- LAT=1: BEAT is high every ACCESS cycle, and idx advances each edge.
- DONE:
  - MOC=1, BUSY=1.
  - SIZE_ERR = latched SIZE==11.
  - Stays in DONE while MOV=1; MOC is never dropped by a timeout.
  - Edge with MOV=0 goes to IDLE; MOC and SIZE_ERR go low that cycle.
- Back-to-back accesses: at least one IDLE cycle separates two accesses. A new MOV is sampled at the first IDLE edge.
- RW/SIZE changes after latching are ignored until the next IDLE.
- Counter width: cnt is CNT_W bits and never exceeds LAT-1; no wrap. idx is 2 bits, max 3.
- ABORT asserts only for a drop in ACCESS, never for the normal drop in DONE.

Test Plan:
- Reset: drive RESET=0 between edges mid-ACCESS (word, idx=2) -> all outputs 0 at once; after release, IDLE with no MOC.
- Byte read, RD_LAT=3: MOV=1, RW=1, SIZE=00 at edge 0 -> BEAT in cycle 3 with BEAT_IDX=0; MOC=1 from cycle 4. Hold MOV 3 more cycles -> MOC stays 1. Drop MOV -> MOC=0 next cycle.
- Word write, WR_LAT=2: SIZE=10, RW=0 -> BEAT pulses in cycles 2, 4, 6, 8 with BEAT_IDX 0, 1, 2, 3; MOC from cycle 9; BUSY 1 for cycles 1..9+.
- Latency 1, halfword read: RD_LAT=1, SIZE=01 -> BEAT in cycles 1 and 2 (idx 0, 1); MOC at cycle 3.
- Abort: word read, drop MOV in cycle 5 -> no further BEAT, state IDLE, ABORT=1 for exactly one cycle, MOC never asserted.
- Reserved size + back-to-back: SIZE=11 -> 4 beats, MOC with SIZE_ERR=1. Drop MOV and re-raise the next cycle -> new access starts after one IDLE cycle; SIZE_ERR=0 for a byte access.
